// File: rtl/seg_region_threshold_ctrl_pkg.sv
// Shared definitions for the region-threshold controller.
//   - default parameter values
//   - configuration field codes
//   - region configuration struct, threshold-only snapshot struct
//   - commit FSM state type
//   - apply_field(): applies one configuration write to a region entry
// Struct fields are sized by the default widths; the controller truncates to
// its own COORD_W / TH_W, so those parameters must not exceed the defaults.
package seg_region_threshold_ctrl_pkg;

  localparam int unsigned NUM_BOX_DEF = 16;
  localparam int unsigned COORD_W_DEF = 12;
  localparam int unsigned TH_W_DEF    = 8;

  localparam logic [3:0] FLD_XMIN  = 4'd0;
  localparam logic [3:0] FLD_XMAX  = 4'd1;
  localparam logic [3:0] FLD_YMIN  = 4'd2;
  localparam logic [3:0] FLD_YMAX  = 4'd3;
  localparam logic [3:0] FLD_BDTHY = 4'd4;
  localparam logic [3:0] FLD_BDTHU = 4'd5;
  localparam logic [3:0] FLD_BDTHV = 4'd6;
  localparam logic [3:0] FLD_BTH   = 4'd7;
  localparam logic [3:0] FLD_BGTH  = 4'd8;
  localparam logic [3:0] FLD_CTRL  = 4'd9;

  typedef logic [COORD_W_DEF-1:0] coord_t;
  typedef logic [TH_W_DEF-1:0]    th_t;

  typedef struct packed {
    coord_t xmin;
    coord_t xmax;
    coord_t ymin;
    coord_t ymax;
    th_t    thY;
    th_t    thU;
    th_t    thV;
    th_t    bth;
    th_t    bgth;
    logic   en;
    logic   upd;
  } region_cfg_t;

  typedef struct packed {
    th_t  thY;
    th_t  thU;
    th_t  thV;
    th_t  bth;
    th_t  bgth;
    logic upd;
  } th_set_t;

  typedef enum logic {
    ST_IDLE,
    ST_ARMED
  } commit_state_e;

  // Geometry and enable/update fields do not exist for the default set.
  function automatic region_cfg_t apply_field(input region_cfg_t cur,
                                              input logic [3:0]  fld,
                                              input coord_t      coord,
                                              input th_t         th,
                                              input logic        is_default);
    region_cfg_t nxt;
    nxt = cur;
    case (fld)
      FLD_XMIN:  if (!is_default) nxt.xmin = coord;
      FLD_XMAX:  if (!is_default) nxt.xmax = coord;
      FLD_YMIN:  if (!is_default) nxt.ymin = coord;
      FLD_YMAX:  if (!is_default) nxt.ymax = coord;
      FLD_BDTHY: nxt.thY  = th;
      FLD_BDTHU: nxt.thU  = th;
      FLD_BDTHV: nxt.thV  = th;
      FLD_BTH:   nxt.bth  = th;
      FLD_BGTH:  nxt.bgth = th;
      FLD_CTRL: begin
        if (!is_default) begin
          nxt.en  = coord[1];
          nxt.upd = coord[0];
        end
      end
      default: ;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/seg_region_threshold_ctrl_hit.sv
// seg_region_hit: combinational point-in-rectangle test for one region.
//   en_i           region enable
//   incl_mode_i    0 = strict (> and <), 1 = inclusive (>= and <=)
//   xmin_i..ymax_i region limits (x = pixel column, y = line)
//   x_i, y_i       pixel coordinates
//   hit_o          pixel lies inside the enabled region
module seg_region_hit #(
  parameter int unsigned COORD_W = 12
) (
  input  logic               en_i,
  input  logic               incl_mode_i,
  input  logic [COORD_W-1:0] xmin_i,
  input  logic [COORD_W-1:0] xmax_i,
  input  logic [COORD_W-1:0] ymin_i,
  input  logic [COORD_W-1:0] ymax_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  output logic               hit_o
);

  logic in_x;
  logic in_y;
  logic ordered;

  always_comb begin
    if (incl_mode_i) begin
      in_x = (x_i >= xmin_i) && (x_i <= xmax_i);
      in_y = (y_i >= ymin_i) && (y_i <= ymax_i);
    end else begin
      in_x = (x_i > xmin_i) && (x_i < xmax_i);
      in_y = (y_i > ymin_i) && (y_i < ymax_i);
    end
    // Already implied by the range tests; kept explicit so an inverted
    // region can never hit regardless of mode.
    ordered = (xmin_i <= xmax_i) && (ymin_i <= ymax_i);
    hit_o   = en_i && ordered && in_x && in_y;
  end

endmodule

// File: rtl/seg_region_threshold_ctrl.sv
// seg_region_threshold_ctrl: selects per-pixel thresholds from up to NUM_BOX
// rectangular regions, falling back to a default set.
//   clk_i, rstn_i              clock, async active-low reset
//   frame_start_i              frame boundary; applies an armed commit
//   pix_valid_i, lineidx_i,
//   pixelidx_i, incl_mode_i    pixel stream and region-edge mode
//   cfg_we_i, cfg_box_i,
//   cfg_field_i, cfg_data_i    shadow-bank write port (box NUM_BOX = default)
//   cfg_commit_i               arm a shadow-to-active swap
//   cfg_ready_o                writes accepted (no swap armed)
//   commit_pending_o           swap armed, waiting for frame start
//   th_valid_o + thresholds,
//   update_o, hit_o, hit_idx_o selected result, 2-cycle latency
module seg_region_threshold_ctrl
  import seg_region_threshold_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_BOX = NUM_BOX_DEF,
  parameter  int unsigned COORD_W = COORD_W_DEF,
  parameter  int unsigned TH_W    = TH_W_DEF,
  localparam int unsigned BOX_W   = $clog2(NUM_BOX + 1),
  localparam int unsigned IDX_W   = (NUM_BOX > 1) ? $clog2(NUM_BOX) : 1
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               frame_start_i,
  input  logic               pix_valid_i,
  input  logic [COORD_W-1:0] lineidx_i,
  input  logic [COORD_W-1:0] pixelidx_i,
  input  logic               incl_mode_i,
  input  logic               cfg_we_i,
  input  logic [BOX_W-1:0]   cfg_box_i,
  input  logic [3:0]         cfg_field_i,
  input  logic [COORD_W-1:0] cfg_data_i,
  input  logic               cfg_commit_i,
  output logic               cfg_ready_o,
  output logic               commit_pending_o,
  output logic               th_valid_o,
  output logic [TH_W-1:0]    BDthY_o,
  output logic [TH_W-1:0]    BDthU_o,
  output logic [TH_W-1:0]    BDthV_o,
  output logic [TH_W-1:0]    Bth_o,
  output logic [TH_W-1:0]    BckGndBuildTH_o,
  output logic               update_o,
  output logic               hit_o,
  output logic [IDX_W-1:0]   hit_idx_o
);

  commit_state_e state_q, state_d;
  region_cfg_t   shadow_q [0:NUM_BOX];
  region_cfg_t   shadow_d [0:NUM_BOX];
  region_cfg_t   active_q [0:NUM_BOX];
  region_cfg_t   active_d [0:NUM_BOX];

  logic   wr_en;
  logic   swap;
  coord_t wr_coord;
  th_t    wr_th;

  logic [NUM_BOX-1:0] hit_vec;

  logic               s1_valid_q, s1_valid_d;
  logic [NUM_BOX-1:0] s1_hit_q, s1_hit_d;
  th_set_t            s1_th_q [0:NUM_BOX];
  th_set_t            s1_th_d [0:NUM_BOX];

  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  th_set_t          sel_th;

  logic             th_valid_q, th_valid_d;
  logic             hit_q, hit_d;
  logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
  logic             update_q, update_d;
  logic [TH_W-1:0]  bdthy_q, bdthy_d;
  logic [TH_W-1:0]  bdthu_q, bdthu_d;
  logic [TH_W-1:0]  bdthv_q, bdthv_d;
  logic [TH_W-1:0]  bth_q, bth_d;
  logic [TH_W-1:0]  bgth_q, bgth_d;

  // Shadow-bank writes; boxes above NUM_BOX match no entry and are dropped.
  always_comb begin
    wr_coord = coord_t'(cfg_data_i);
    wr_th    = th_t'(cfg_data_i[TH_W-1:0]);
    wr_en    = cfg_we_i && (state_q == ST_IDLE);
    shadow_d = shadow_q;
    for (int unsigned k = 0; k <= NUM_BOX; k++) begin
      if (wr_en && (cfg_box_i == BOX_W'(k))) begin
        shadow_d[k] = apply_field(shadow_q[k], cfg_field_i, wr_coord, wr_th,
                                  k == NUM_BOX);
      end
    end
  end

  // Commit handling. The copy takes shadow_d so a write in the swap cycle is
  // included; a commit coinciding with frame start swaps without arming.
  always_comb begin
    state_d = state_q;
    swap    = 1'b0;
    if (frame_start_i && ((state_q == ST_ARMED) || cfg_commit_i)) begin
      swap    = 1'b1;
      state_d = ST_IDLE;
    end else if (cfg_commit_i) begin
      state_d = ST_ARMED;
    end
    active_d = swap ? shadow_d : active_q;
  end

  // Comparators see active_d so a pixel sampled on the swap edge already
  // uses the new bank.
  for (genvar k = 0; k < NUM_BOX; k++) begin : g_region
    seg_region_hit #(
      .COORD_W (COORD_W)
    ) u_hit (
      .en_i        (active_d[k].en),
      .incl_mode_i (incl_mode_i),
      .xmin_i      (COORD_W'(active_d[k].xmin)),
      .xmax_i      (COORD_W'(active_d[k].xmax)),
      .ymin_i      (COORD_W'(active_d[k].ymin)),
      .ymax_i      (COORD_W'(active_d[k].ymax)),
      .x_i         (pixelidx_i),
      .y_i         (lineidx_i),
      .hit_o       (hit_vec[k])
    );
  end

  // Stage 1 also snapshots the active thresholds so a swap landing between
  // the stages cannot change results for pixels already in flight.
  always_comb begin
    s1_valid_d = pix_valid_i;
    s1_hit_d   = s1_hit_q;
    s1_th_d    = s1_th_q;
    if (pix_valid_i) begin
      s1_hit_d = hit_vec;
      for (int unsigned k = 0; k <= NUM_BOX; k++) begin
        s1_th_d[k].thY  = active_d[k].thY;
        s1_th_d[k].thU  = active_d[k].thU;
        s1_th_d[k].thV  = active_d[k].thV;
        s1_th_d[k].bth  = active_d[k].bth;
        s1_th_d[k].bgth = active_d[k].bgth;
        s1_th_d[k].upd  = active_d[k].upd;
      end
    end
  end

  // Lowest-index hit wins; no hit selects the default set with update forced.
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_th     = s1_th_q[NUM_BOX];
    sel_th.upd = 1'b1;
    for (int unsigned k = 0; k < NUM_BOX; k++) begin
      if (!sel_found && s1_hit_q[k]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(k);
        sel_th    = s1_th_q[k];
      end
    end
  end

  always_comb begin
    th_valid_d = s1_valid_q;
    hit_d      = hit_q;
    hit_idx_d  = hit_idx_q;
    update_d   = update_q;
    bdthy_d    = bdthy_q;
    bdthu_d    = bdthu_q;
    bdthv_d    = bdthv_q;
    bth_d      = bth_q;
    bgth_d     = bgth_q;
    if (s1_valid_q) begin
      hit_d     = sel_found;
      hit_idx_d = sel_idx;
      update_d  = sel_th.upd;
      bdthy_d   = TH_W'(sel_th.thY);
      bdthu_d   = TH_W'(sel_th.thU);
      bdthv_d   = TH_W'(sel_th.thV);
      bth_d     = TH_W'(sel_th.bth);
      bgth_d    = TH_W'(sel_th.bgth);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      shadow_q   <= '{default: '0};
      active_q   <= '{default: '0};
      s1_valid_q <= 1'b0;
      s1_hit_q   <= '0;
      s1_th_q    <= '{default: '0};
      th_valid_q <= 1'b0;
      hit_q      <= 1'b0;
      hit_idx_q  <= '0;
      update_q   <= 1'b0;
      bdthy_q    <= '0;
      bdthu_q    <= '0;
      bdthv_q    <= '0;
      bth_q      <= '0;
      bgth_q     <= '0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      s1_valid_q <= s1_valid_d;
      s1_hit_q   <= s1_hit_d;
      s1_th_q    <= s1_th_d;
      th_valid_q <= th_valid_d;
      hit_q      <= hit_d;
      hit_idx_q  <= hit_idx_d;
      update_q   <= update_d;
      bdthy_q    <= bdthy_d;
      bdthu_q    <= bdthu_d;
      bdthv_q    <= bdthv_d;
      bth_q      <= bth_d;
      bgth_q     <= bgth_d;
    end
  end

  assign commit_pending_o = (state_q == ST_ARMED);
  assign cfg_ready_o      = (state_q == ST_IDLE);
  assign th_valid_o       = th_valid_q;
  assign hit_o            = hit_q;
  assign hit_idx_o        = hit_idx_q;
  assign update_o         = update_q;
  assign BDthY_o          = bdthy_q;
  assign BDthU_o          = bdthu_q;
  assign BDthV_o          = bdthv_q;
  assign Bth_o            = bth_q;
  assign BckGndBuildTH_o  = bgth_q;

endmodule

// File: doc/seg_region_threshold_ctrl.md
SEG_REGION_THRESHOLD_CTRL -- requirements
Module: seg_region_threshold_ctrl

Interface
REQ-001 The block SHALL have the following parameters, each listed as name, default, meaning:
- NUM_BOX, 16, number of threshold regions.
- COORD_W, 12, line/pixel index width.
- TH_W, 8, threshold width.
REQ-002 The block SHALL have the following ports, each listed as name, direction, width, meaning:
- clk_i, in, 1, single clock.
- rstn_i, in, 1, asynchronous active-low reset.
- frame_start_i, in, 1, one-cycle pulse at frame start.
- pix_valid_i, in, 1, pixel qualifier.
- lineidx_i, in, COORD_W, pixel line index.
- pixelidx_i, in, COORD_W, pixel column index.
- incl_mode_i, in, 1, region-edge mode: 0 = strict (> and <), 1 = inclusive (>= and <=).
- cfg_we_i, in, 1, configuration write strobe.
- cfg_box_i, in, clog2(NUM_BOX+1), target region; value NUM_BOX selects the default set.
- cfg_field_i, in, 4, target field within the region.
- cfg_data_i, in, COORD_W, write data; thresholds use the low TH_W bits.
- cfg_commit_i, in, 1, request a shadow-to-active swap.
- cfg_ready_o, out, 1, writes are accepted.
- commit_pending_o, out, 1, a swap is armed.
- th_valid_o, out, 1, output qualifier.
- BDthY_o, BDthU_o, BDthV_o, Bth_o, BckGndBuildTH_o, out, TH_W each, selected thresholds.
- update_o, out, 1, selected update flag.
- hit_o, out, 1, pixel lies inside some enabled region.
- hit_idx_o, out, clog2(NUM_BOX), index of the winning region.

Function
REQ-003 Field codes SHALL be: 0 xmin, 1 xmax, 2 ymin, 3 ymax, 4 BDthY, 5 BDthU, 6 BDthV, 7 Bth, 8 BckGndBuildTH, 9 {data[1]=enable, data[0]=update}.
REQ-004 Writes to field codes 10-15, to cfg_box_i > NUM_BOX, and to fields 0-3 or 9 of the default set SHALL be ignored.
REQ-005 A write SHALL take effect only when cfg_we_i and cfg_ready_o are both high, and SHALL update the shadow bank only.
REQ-006 cfg_ready_o SHALL equal !commit_pending_o.
REQ-007 cfg_commit_i SHALL set commit_pending_o on the next edge.
REQ-008 On the first frame_start_i that occurs while commit_pending_o is high, the shadow bank SHALL be copied to the active bank and commit_pending_o SHALL clear on the same edge.
REQ-009 If cfg_commit_i and frame_start_i are high in the same cycle, the copy SHALL occur on that edge.
REQ-010 A write and a commit in the same cycle SHALL be included in the copy.
REQ-011 Region k SHALL hit when it is enabled and both lineidx_i and pixelidx_i satisfy the incl_mode_i comparison against its active limits.
REQ-012 A region with min > max SHALL never hit.
REQ-013 When several regions hit, the lowest index SHALL win.
REQ-014 When no region hits, outputs SHALL carry the default set, with update_o=1, hit_o=0 and hit_idx_o=0.
REQ-015 The pipeline SHALL be two stages: stage 1 registers the per-region hit vector together with pix_valid_i; stage 2 registers the priority-selected outputs. Latency SHALL be 2 cycles at full throughput, and th_valid_o SHALL equal pix_valid_i delayed by 2 cycles.
REQ-016 A bank swap SHALL affect only pixels sampled on or after the swap edge; pixels already in the pipeline SHALL complete with their captured results.
REQ-017 When pix_valid_i is low, the stage registers SHALL hold their data and the valid bit SHALL propagate low.
REQ-018 All comparisons SHALL be unsigned at COORD_W bits; thresholds SHALL be truncated from cfg_data_i to TH_W bits.

Reset
REQ-019 Asserting rstn_i SHALL immediately clear both banks: all regions disabled, all coordinates and thresholds 0, default thresholds 0.
REQ-020 Under reset, commit_pending_o SHALL be 0 and cfg_ready_o SHALL be 1.
REQ-021 Under reset, th_valid_o, hit_o, hit_idx_o, update_o and all threshold outputs SHALL be 0.
REQ-022 A reset asserted mid-frame or while a commit is pending SHALL discard both the pending commit and any pipeline contents.

Structure
REQ-023 A shared package SHALL hold the field-code constants, a region-configuration struct {xmin, xmax, ymin, ymax, thY, thU, thV, bth, bgth, en, upd}, and the default parameter values.
REQ-024 The per-region comparator SHALL be one sub-module, seg_region_hit, instantiated NUM_BOX times through a generate loop.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Program region 0 as x 10..20, y 10..20, thY=0x33, enabled; commit; pulse frame_start; pixel (15,15) -> two cycles later th_valid_o=1, BDthY_o=0x33, hit_idx_o=0.
- Same setup, pixel (10,15): with incl_mode_i=0 -> default set and update_o=1; with incl_mode_i=1 -> region 0 values.
- Regions 2 and 5 overlap at (50,50) -> hit_idx_o=2.
- Write region 1 and commit without a frame_start -> outputs unchanged and cfg_ready_o=0; a write attempted meanwhile is dropped; after frame_start the new values apply.
- cfg_commit_i and frame_start_i in the same cycle -> swap on that edge; commit_pending_o never rises.
- Assert rstn_i low mid-stream with a commit pending -> all outputs 0 and commit_pending_o=0; after release, any pixel returns the zeroed default set with update_o=1.
